cpu_run_monitor: RTL and testbench

- Synthesizable run controller and self-checker for the single-cycle RISC-V core.
- Sequences CPU reset release, counts cycles and retired register writes, detects program halt or timeout, and compares NUM_CH watched architectural registers against expected values.
- Sits between the bench/top level and SingleCycleCPU and reports one pass/fail verdict per run.
- Replaces hand inspection of register traces.

---
 rtl/cpu_run_monitor.sv | 131 +++++++++++++
 tb/tb_cpu_run_monitor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// Run controller and register self-checker for the single-cycle RISC-V core.
// Releases CPU reset, watches retired writes, detects halt/timeout and issues one verdict.
//
// state | meaning
// HOLD  | CPU held in reset for RST_CYCLES cycles
// RUN   | CPU running; counting cycles/commits, capturing watched registers
// CHECK | CPU frozen; compare shadows against expected values
// DONE  | verdict latched until start drops
module cpu_run_monitor #(
  parameter int          DATA_W     = 32,
  parameter int          NUM_CH     = 4,
  parameter int          RST_CYCLES = 2,
  parameter int          TIMEOUT    = 300,
  parameter int          STALL_LIM  = 4,
  parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
  input  logic                     clk,
  input  logic                     start,
  input  logic [DATA_W-1:0]        pc_i,
  input  logic [31:0]              instr_i,
  input  logic                     rf_wen,
  input  logic [4:0]               rf_waddr,
  input  logic [DATA_W-1:0]        rf_wdata,
  input  logic [5*NUM_CH-1:0]      watch_idx,
  input  logic [DATA_W*NUM_CH-1:0] exp_data,
  output logic                     cpu_rst_n,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [NUM_CH-1:0]        mismatch,
  output logic [15:0]              cycle_cnt,
  output logic [15:0]              commit_cnt
);

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SW = (STALL_LIM > 1) ? $clog2(STALL_LIM) : 1;

  typedef enum logic [1:0] {HOLD, RUN, CHECK, DONE} state_t;

  state_t              state;
  logic [HW-1:0]       hold_cnt;
  logic [SW-1:0]       stall_cnt;
  logic [SW-1:0]       stall_nxt;
  logic [DATA_W-1:0]   pc_prev;
  logic [DATA_W-1:0]   shadow [NUM_CH];
  logic [NUM_CH-1:0]   mis_nxt;
  logic                halt;
  logic                commit;
  logic                tmo;

  // Stall count saturates at the halt threshold so a long self-loop cannot wrap.
  always_comb begin
    stall_nxt = '0;
    if (pc_i == pc_prev) begin
      if (stall_cnt == SW'(STALL_LIM - 1)) stall_nxt = stall_cnt;
      else                                 stall_nxt = stall_cnt + SW'(1);
    end
  end

  assign halt   = (instr_i == HALT_INSTR) || (stall_nxt == SW'(STALL_LIM - 1));
  assign commit = rf_wen && (rf_waddr != 5'd0);
  assign tmo    = (cycle_cnt == 16'(TIMEOUT - 1));

  always_comb begin
    mis_nxt = '0;
    for (int k = 0; k < NUM_CH; k++)
      mis_nxt[k] = (shadow[k] != exp_data[k*DATA_W +: DATA_W]);
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      stall_cnt  <= '0;
      pc_prev    <= '0;
      cpu_rst_n  <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      mismatch   <= '0;
      cycle_cnt  <= '0;
      commit_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
    end else begin
      case (state)
        HOLD: begin
          hold_cnt <= hold_cnt + HW'(1);
          pc_prev  <= pc_i;
          if (hold_cnt == HW'(RST_CYCLES - 1)) begin
            state     <= RUN;
            cpu_rst_n <= 1'b1;
          end
        end
        RUN: begin
          pc_prev   <= pc_i;
          stall_cnt <= stall_nxt;
          if (cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
          if (commit) begin
            if (commit_cnt != 16'hFFFF) commit_cnt <= commit_cnt + 16'd1;
            for (int k = 0; k < NUM_CH; k++)
              if (watch_idx[5*k +: 5] == rf_waddr) shadow[k] <= rf_wdata;
          end
          // Halt takes priority over a timeout landing on the same cycle.
          if (halt) begin
            state     <= CHECK;
            cpu_rst_n <= 1'b0;
          end else if (tmo) begin
            state     <= DONE;
            cpu_rst_n <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            timeout   <= 1'b1;
          end
        end
        CHECK: begin
          mismatch <= mis_nxt;
          pass     <= ~|mis_nxt;
          fail     <= |mis_nxt;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: a tiny table-driven CPU model feeds the
// monitor, and each run's verdict, counters and latency are compared to hand values.
module tb_cpu_run_monitor;

  logic         clk;
  logic         start;
  logic [31:0]  pc_i;
  logic [31:0]  instr_i;
  logic         rf_wen;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [19:0]  watch_idx;
  logic [127:0] exp_data;
  logic         cpu_rst_n;
  logic         done;
  logic         pass;
  logic         fail;
  logic         timeout;
  logic [3:0]   mismatch;
  logic [15:0]  cycle_cnt;
  logic [15:0]  commit_cnt;

  int n_chk = 0;
  int n_bad = 0;

  // Program table indexed by instruction slot; pc = slot*4.
  logic [31:0] mem_instr [16];
  logic        mem_wen   [16];
  logic [4:0]  mem_waddr [16];
  logic [31:0] mem_wdata [16];
  int          mem_next  [16];

  cpu_run_monitor #(.TIMEOUT(50)) dut (
    .clk        (clk),
    .start      (start),
    .pc_i       (pc_i),
    .instr_i    (instr_i),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .watch_idx  (watch_idx),
    .exp_data   (exp_data),
    .cpu_rst_n  (cpu_rst_n),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .mismatch   (mismatch),
    .cycle_cnt  (cycle_cnt),
    .commit_cnt (commit_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem_instr[i] = 32'h00000013;
      mem_wen[i]   = 1'b0;
      mem_waddr[i] = 5'd0;
      mem_wdata[i] = 32'h0;
      mem_next[i]  = i;
    end
  endtask

  task automatic set_ins(input int i, input logic [31:0] ins, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input int nxt);
    mem_instr[i] = ins;
    mem_wen[i]   = we;
    mem_waddr[i] = wa;
    mem_wdata[i] = wd;
    mem_next[i]  = nxt;
  endtask

  // x1=5, x2=7, x3=12, then jal x0,0 at slot 3.
  task automatic load_basic();
    clear_mem();
    set_ins(0, 32'h00500093, 1'b1, 5'd1, 32'h5, 1);
    set_ins(1, 32'h00700113, 1'b1, 5'd2, 32'h7, 2);
    set_ins(2, 32'h00C00193, 1'b1, 5'd3, 32'hC, 3);
    set_ins(3, 32'h0000006F, 1'b0, 5'd0, 32'h0, 3);
  endtask

  // Single-cycle CPU stand-in: holds pc=0 in reset, steps one slot per cycle when running.
  initial begin : cpu_model
    int  idx = 0;
    bit  running = 1'b0;
    pc_i = '0; instr_i = '0; rf_wen = 1'b0; rf_waddr = '0; rf_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!cpu_rst_n) begin
        running = 1'b0;
        idx     = 0;
        rf_wen  = 1'b0;
      end else begin
        if (running) idx = mem_next[idx];
        running = 1'b1;
        rf_wen  = mem_wen[idx];
      end
      pc_i     = 32'(idx * 4);
      instr_i  = mem_instr[idx];
      rf_waddr = mem_waddr[idx];
      rf_wdata = mem_wdata[idx];
    end
  end

  // Counts samples with cpu_rst_n low until it rises; returns at the first RUN-cycle negedge.
  task automatic wait_run(output int h);
    h = 0;
    while (!cpu_rst_n && h < 20) begin
      h++;
      @(negedge clk);
    end
  endtask

  // Called at the first RUN negedge (r=0); returns the index of the first negedge with done=1.
  task automatic wait_done(output int r);
    r = 0;
    while (!done && r < 400) begin
      @(negedge clk);
      r++;
    end
  endtask

  task automatic check_verdict(input string nm, input int exp_r, input int r,
                               input logic ep, input logic ef, input logic et,
                               input logic [3:0] em, input int ecyc, input int ecom);
    chk({nm, "_latency"}, r, exp_r);
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_pass"}, pass, ep);
    chk({nm, "_fail"}, fail, ef);
    chk({nm, "_timeout"}, timeout, et);
    chk({nm, "_mismatch"}, mismatch, em);
    chk({nm, "_cycle_cnt"}, cycle_cnt, ecyc);
    chk({nm, "_commit_cnt"}, commit_cnt, ecom);
    repeat (3) @(negedge clk);
    chk({nm, "_hold_done"}, done, 1'b1);
    chk({nm, "_hold_cpu_rst"}, cpu_rst_n, 1'b0);
    chk({nm, "_hold_cycle"}, cycle_cnt, ecyc);
    chk({nm, "_hold_pass"}, pass, ep);
  endtask

  task automatic run_case(input string nm, input int exp_r,
                          input logic ep, input logic ef, input logic et,
                          input logic [3:0] em, input int ecyc, input int ecom);
    int h;
    int r;
    start = 1'b0;
    @(negedge clk);
    chk({nm, "_rst_cpu"}, cpu_rst_n, 1'b0);
    chk({nm, "_rst_done"}, done, 1'b0);
    chk({nm, "_rst_cycle"}, cycle_cnt, 16'd0);
    @(negedge clk);
    start = 1'b1;
    wait_run(h);
    chk({nm, "_hold_len"}, h, 2);
    wait_done(r);
    check_verdict(nm, exp_r, r, ep, ef, et, em, ecyc, ecom);
  endtask

  initial begin : main
    int h;
    int r;
    start     = 1'b0;
    watch_idx = '0;
    exp_data  = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("por_cpu_rst", cpu_rst_n, 1'b0);
    chk("por_verdict", {done, pass, fail, timeout, mismatch}, 8'h00);

    // Loop entered at r=3, halts at r=6 after 4 equal pcs, done at r=8.
    load_basic();
    watch_idx = {5'd3, 5'd2, 5'd1, 5'd15};
    exp_data  = {32'hC, 32'h7, 32'h5, 32'h0};
    run_case("basic", 8, 1'b1, 1'b0, 1'b0, 4'b0000, 7, 3);

    exp_data  = {32'hC, 32'h8, 32'h5, 32'h0};
    run_case("mism", 8, 1'b0, 1'b1, 1'b0, 4'b0100, 7, 3);

    // pc alternates 0/4 forever; expected values deliberately wrong to show timeout skips the compare.
    clear_mem();
    set_ins(0, 32'h00128293, 1'b1, 5'd5, 32'h1, 1);
    set_ins(1, 32'hFFDFF06F, 1'b0, 5'd0, 32'h0, 0);
    watch_idx = {5'd5, 5'd5, 5'd5, 5'd5};
    exp_data  = '0;
    run_case("tmo", 50, 1'b0, 1'b1, 1'b1, 4'b0000, 50, 25);

    // x0 writes must neither count nor load the channels watching x0; ebreak at slot 3.
    clear_mem();
    set_ins(0, 32'h05500013, 1'b1, 5'd0, 32'h55, 1);
    set_ins(1, 32'h00900093, 1'b1, 5'd1, 32'h9, 2);
    set_ins(2, 32'h07700013, 1'b1, 5'd0, 32'h77, 3);
    set_ins(3, 32'h00100073, 1'b0, 5'd0, 32'h0, 3);
    watch_idx = {5'd1, 5'd0, 5'd1, 5'd0};
    exp_data  = {32'h9, 32'h0, 32'h9, 32'h0};
    run_case("x0", 5, 1'b1, 1'b0, 1'b0, 4'b0000, 4, 1);

    // Halt slot also retires a write to x1; both x1 channels must see the final value.
    clear_mem();
    set_ins(0, 32'h01100093, 1'b1, 5'd1, 32'h11, 1);
    set_ins(1, 32'h02200113, 1'b1, 5'd2, 32'h22, 2);
    set_ins(2, 32'h00100073, 1'b1, 5'd1, 32'h99, 2);
    watch_idx = {5'd5, 5'd2, 5'd1, 5'd1};
    exp_data  = {32'h0, 32'h22, 32'h99, 32'h99};
    run_case("dual", 4, 1'b1, 1'b0, 1'b0, 4'b0000, 3, 3);

    // Abort mid-run with a 3 ns low pulse, then the rerun must give the basic verdict.
    load_basic();
    watch_idx = {5'd3, 5'd2, 5'd1, 5'd15};
    exp_data  = {32'hC, 32'h7, 32'h5, 32'h0};
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    wait_run(h);
    chk("abort_hold_len", h, 2);
    repeat (3) @(posedge clk);
    #2;
    chk("abort_pre_cycle", cycle_cnt, 16'd3);
    chk("abort_pre_commit", commit_cnt, 16'd3);
    #1 start = 1'b0;
    #1;
    chk("abort_cpu_rst", cpu_rst_n, 1'b0);
    chk("abort_cycle", cycle_cnt, 16'd0);
    chk("abort_commit", commit_cnt, 16'd0);
    chk("abort_verdict", {done, pass, fail, timeout, mismatch}, 8'h00);
    #2 start = 1'b1;
    wait_run(h);
    chk("abort_rehold_len", h, 2);
    wait_done(r);
    check_verdict("abort_rerun", 8, r, 1'b1, 1'b0, 1'b0, 4'b0000, 7, 3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
